// File: rtl/controller_sequencer.sv
// SAP-1 style controller/sequencer: six-state T ring plus HALT, decoding the control word from state and opcode.
// Optional macro SAP1_VARIABLE_CYCLE_EN shortens instructions by returning to T1 after their last active T-state.

module controller_sequencer_chk (
   input logic ep,
   input logic ce_n,
   input logic ei_n,
   input logic ea,
   input logic eu
);

   logic [2:0] drv_cnt_s;

   // Count the active bus drivers and flag any contention on the shared bus
   always_comb begin
      drv_cnt_s = 3'd0;
      drv_cnt_s = {2'b00, ep} + {2'b00, ~ce_n} + {2'b00, ~ei_n} + {2'b00, ea} + {2'b00, eu};
      assert (drv_cnt_s <= 3'd1)
         else $error("bus contention: %0d drivers active", drv_cnt_s);
   end

endmodule

module controller_sequencer #(
   parameter logic [3:0] OP_LDA = 4'h0,
   parameter logic [3:0] OP_ADD = 4'h1,
   parameter logic [3:0] OP_SUB = 4'h2,
   parameter logic [3:0] OP_OUT = 4'hE,
   parameter logic [3:0] OP_HLT = 4'hF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   output logic       cp,
   output logic       ep,
   output logic       lm_n,
   output logic       ce_n,
   output logic       li_n,
   output logic       ei_n,
   output logic       la_n,
   output logic       ea,
   output logic       su,
   output logic       eu,
   output logic       lb_n,
   output logic       lo_n,
   output logic [5:0] t_state,
   output logic       halt
);

   typedef enum logic [2:0] {
      ST_T1   = 3'd0,
      ST_T2   = 3'd1,
      ST_T3   = 3'd2,
      ST_T4   = 3'd3,
      ST_T5   = 3'd4,
      ST_T6   = 3'd5,
      ST_HALT = 3'd6
   } state_e;

   state_e state_q;
   state_e state_d;

   logic is_lda_s;
   logic is_alu_s;
   logic is_sub_s;
   logic is_out_s;

   // Opcode classes; ADD and SUB share the same bus micro-steps
   always_comb begin
      is_lda_s = (opcode == OP_LDA);
      is_sub_s = (opcode == OP_SUB);
      is_alu_s = (opcode == OP_ADD) || (opcode == OP_SUB);
      is_out_s = (opcode == OP_OUT);
   end

   // State register; reset parks the ring at T1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_T1;
      end else begin
         state_q <= state_d;
      end
   end

   // Ring progression; HALT is terminal and only reachable from T4
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_T1: state_d = ST_T2;
         ST_T2: state_d = ST_T3;
         ST_T3: state_d = ST_T4;
         ST_T4: begin
            if (opcode == OP_HLT) begin
               state_d = ST_HALT;
            end else begin
`ifdef SAP1_VARIABLE_CYCLE_EN
               if (is_lda_s || is_alu_s) begin
                  state_d = ST_T5;
               end else begin
                  state_d = ST_T1;
               end
`else
               state_d = ST_T5;
`endif
            end
         end
         ST_T5: begin
`ifdef SAP1_VARIABLE_CYCLE_EN
            if (is_alu_s) begin
               state_d = ST_T6;
            end else begin
               state_d = ST_T1;
            end
`else
            state_d = ST_T6;
`endif
         end
         ST_T6:   state_d = ST_T1;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_T1;
      endcase
   end

   // Control word decode; every unlisted state/opcode pair yields the idle word
   always_comb begin
      cp   = 1'b0;
      ep   = 1'b0;
      lm_n = 1'b1;
      ce_n = 1'b1;
      li_n = 1'b1;
      ei_n = 1'b1;
      la_n = 1'b1;
      ea   = 1'b0;
      su   = 1'b0;
      eu   = 1'b0;
      lb_n = 1'b1;
      lo_n = 1'b1;
      case (state_q)
         ST_T1: begin
            ep   = 1'b1;
            lm_n = 1'b0;
         end
         ST_T2: cp = 1'b1;
         ST_T3: begin
            ce_n = 1'b0;
            li_n = 1'b0;
         end
         ST_T4: begin
            if (is_lda_s || is_alu_s) begin
               ei_n = 1'b0;
               lm_n = 1'b0;
            end else if (is_out_s) begin
               ea   = 1'b1;
               lo_n = 1'b0;
            end else begin
               cp = 1'b0;
            end
         end
         ST_T5: begin
            if (is_lda_s) begin
               ce_n = 1'b0;
               la_n = 1'b0;
            end else if (is_alu_s) begin
               ce_n = 1'b0;
               lb_n = 1'b0;
               su   = is_sub_s;
            end else begin
               cp = 1'b0;
            end
         end
         ST_T6: begin
            if (is_alu_s) begin
               eu   = 1'b1;
               la_n = 1'b0;
               su   = is_sub_s;
            end else begin
               cp = 1'b0;
            end
         end
         ST_HALT: cp = 1'b0;
         default: cp = 1'b0;
      endcase
   end

   // One-hot T-state view and halt flag
   always_comb begin
      t_state = 6'b000000;
      halt    = 1'b0;
      case (state_q)
         ST_T1:   t_state = 6'b000001;
         ST_T2:   t_state = 6'b000010;
         ST_T3:   t_state = 6'b000100;
         ST_T4:   t_state = 6'b001000;
         ST_T5:   t_state = 6'b010000;
         ST_T6:   t_state = 6'b100000;
         ST_HALT: halt    = 1'b1;
         default: t_state = 6'b000000;
      endcase
   end

   controller_sequencer_chk u_chk (
      .ep   (ep),
      .ce_n (ce_n),
      .ei_n (ei_n),
      .ea   (ea),
      .eu   (eu)
   );

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed self-checking bench for controller_sequencer; expectations follow SAP1_VARIABLE_CYCLE_EN when defined.

module tb_controller_sequencer;

   localparam logic [11:0] CW_IDLE = 12'h3E3;
   localparam logic [11:0] CW_T1   = 12'h5E3;
   localparam logic [11:0] CW_T2   = 12'hBE3;
   localparam logic [11:0] CW_T3   = 12'h263;
   localparam logic [11:0] CW_T4M  = 12'h1A3;
   localparam logic [11:0] CW_LDA5 = 12'h2C3;
   localparam logic [11:0] CW_ADD5 = 12'h2E1;
   localparam logic [11:0] CW_SUB5 = 12'h2E9;
   localparam logic [11:0] CW_ADD6 = 12'h3C7;
   localparam logic [11:0] CW_SUB6 = 12'h3CF;
   localparam logic [11:0] CW_OUT4 = 12'h3F2;

   logic       clk;
   logic       reset;
   logic [3:0] opcode;
   logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
   logic [5:0] t_state;
   logic       halt;
   logic [11:0] cw;

   int total;
   int bad;

   assign cw = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n};

   controller_sequencer dut (
      .clk(clk), .reset(reset), .opcode(opcode),
      .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n),
      .la_n(la_n), .ea(ea), .su(su), .eu(eu), .lb_n(lb_n), .lo_n(lo_n),
      .t_state(t_state), .halt(halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #2;
      reset = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      opcode = 4'h0;
      #1;
      total++;
      if (cw !== CW_T1 || t_state !== 6'b000001 || halt !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: cw=%h ts=%b halt=%b, want cw=%h ts=000001 halt=0", cw, t_state, halt, CW_T1);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   task automatic test_lda();
      logic [11:0] ecw [0:6];
      logic [5:0]  ets [0:6];
      int n;
      opcode = 4'h0;
      do_reset();
`ifdef SAP1_VARIABLE_CYCLE_EN
      n = 6;
      ecw[0] = CW_T1;  ets[0] = 6'b000001;
      ecw[1] = CW_T2;  ets[1] = 6'b000010;
      ecw[2] = CW_T3;  ets[2] = 6'b000100;
      ecw[3] = CW_T4M; ets[3] = 6'b001000;
      ecw[4] = CW_LDA5; ets[4] = 6'b010000;
      ecw[5] = CW_T1;  ets[5] = 6'b000001;
      ecw[6] = CW_T1;  ets[6] = 6'b000001;
`else
      n = 7;
      ecw[0] = CW_T1;  ets[0] = 6'b000001;
      ecw[1] = CW_T2;  ets[1] = 6'b000010;
      ecw[2] = CW_T3;  ets[2] = 6'b000100;
      ecw[3] = CW_T4M; ets[3] = 6'b001000;
      ecw[4] = CW_LDA5; ets[4] = 6'b010000;
      ecw[5] = CW_IDLE; ets[5] = 6'b100000;
      ecw[6] = CW_T1;  ets[6] = 6'b000001;
`endif
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         total++;
         if (cw !== ecw[i] || t_state !== ets[i] || halt !== 1'b0) begin
            bad++;
            $display("FAIL lda_step%0d: cw=%h ts=%b, want cw=%h ts=%b", i, cw, t_state, ecw[i], ets[i]);
         end
      end
   endtask

   task automatic test_add_sub();
      logic [11:0] ecw [0:6];
      logic [5:0]  ets [0:6];
      for (int k = 0; k < 2; k++) begin
         opcode = (k == 0) ? 4'h1 : 4'h2;
         do_reset();
         ecw[0] = CW_T1;  ets[0] = 6'b000001;
         ecw[1] = CW_T2;  ets[1] = 6'b000010;
         ecw[2] = CW_T3;  ets[2] = 6'b000100;
         ecw[3] = CW_T4M; ets[3] = 6'b001000;
         ecw[4] = (k == 0) ? CW_ADD5 : CW_SUB5; ets[4] = 6'b010000;
         ecw[5] = (k == 0) ? CW_ADD6 : CW_SUB6; ets[5] = 6'b100000;
         ecw[6] = CW_T1;  ets[6] = 6'b000001;
         for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
               @(posedge clk);
               #1;
            end
            total++;
            if (cw !== ecw[i] || t_state !== ets[i]) begin
               bad++;
               $display("FAIL alu%0d_step%0d: cw=%h ts=%b, want cw=%h ts=%b", k, i, cw, t_state, ecw[i], ets[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_add();
      logic la_seen;
      opcode = 4'h1;
      do_reset();
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (cw !== CW_ADD5 || t_state !== 6'b010000) begin
         bad++;
         $display("FAIL add_t5: cw=%h ts=%b, want cw=%h ts=010000", cw, t_state, CW_ADD5);
      end
      reset = 1'b0;
      #1;
      total++;
      if (cw !== CW_T1 || t_state !== 6'b000001) begin
         bad++;
         $display("FAIL add_async_reset: cw=%h ts=%b, want cw=%h ts=000001", cw, t_state, CW_T1);
      end
      la_seen = la_n;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (t_state !== 6'b000010 || la_seen !== 1'b1) begin
         bad++;
         $display("FAIL add_after_release: ts=%b la_n=%b, want ts=000010 la_n=1", t_state, la_seen);
      end
   endtask

   task automatic test_halt();
      opcode = 4'hF;
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (cw !== CW_IDLE || t_state !== 6'b001000 || halt !== 1'b0) begin
         bad++;
         $display("FAIL hlt_t4: cw=%h ts=%b halt=%b, want cw=%h ts=001000 halt=0", cw, t_state, halt, CW_IDLE);
      end
      for (int i = 0; i < 21; i++) begin
         @(posedge clk);
         #1;
         opcode = 4'(i);
         total++;
         if (cw !== CW_IDLE || t_state !== 6'b000000 || halt !== 1'b1) begin
            bad++;
            $display("FAIL halt_hold%0d: cw=%h ts=%b halt=%b, want cw=%h ts=000000 halt=1", i, cw, t_state, halt, CW_IDLE);
         end
      end
      reset = 1'b0;
      #1;
      total++;
      if (cw !== CW_T1 || t_state !== 6'b000001 || halt !== 1'b0) begin
         bad++;
         $display("FAIL halt_reset: cw=%h ts=%b halt=%b, want cw=%h ts=000001 halt=0", cw, t_state, halt, CW_T1);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_short_ops();
      logic [11:0] ecw [0:6];
      logic [5:0]  ets [0:6];
      for (int k = 0; k < 2; k++) begin
         opcode = (k == 0) ? 4'h7 : 4'hE;
         do_reset();
         ecw[0] = CW_T1;  ets[0] = 6'b000001;
         ecw[1] = CW_T2;  ets[1] = 6'b000010;
         ecw[2] = CW_T3;  ets[2] = 6'b000100;
         ecw[3] = (k == 0) ? CW_IDLE : CW_OUT4; ets[3] = 6'b001000;
`ifdef SAP1_VARIABLE_CYCLE_EN
         ecw[4] = CW_T1;  ets[4] = 6'b000001;
         ecw[5] = CW_T2;  ets[5] = 6'b000010;
         ecw[6] = CW_T3;  ets[6] = 6'b000100;
`else
         ecw[4] = CW_IDLE; ets[4] = 6'b010000;
         ecw[5] = CW_IDLE; ets[5] = 6'b100000;
         ecw[6] = CW_T1;  ets[6] = 6'b000001;
`endif
         for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
               @(posedge clk);
               #1;
            end
            total++;
            if (cw !== ecw[i] || t_state !== ets[i]) begin
               bad++;
               $display("FAIL short%0d_step%0d: cw=%h ts=%b, want cw=%h ts=%b", k, i, cw, t_state, ecw[i], ets[i]);
            end
         end
      end
   endtask

   task automatic test_bus_drivers();
      int drv;
      for (int op = 0; op < 16; op++) begin
         opcode = 4'(op);
         do_reset();
         for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
               @(posedge clk);
               #1;
            end
            drv = int'(ep) + int'(~ce_n) + int'(~ei_n) + int'(ea) + int'(eu);
            total++;
            if (drv > 1) begin
               bad++;
               $display("FAIL bus_drivers op%0h step%0d: drivers=%0d, want <=1", op, i, drv);
            end
         end
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      reset  = 1'b0;
      opcode = 4'h0;
      test_reset();
      test_lda();
      test_add_sub();
      test_reset_mid_add();
      test_halt();
      test_short_ops();
      test_bus_drivers();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
